// File: rtl/logic_unit_pipe.sv
// Pipelined WIDTH-bit bitwise logic unit with accumulator feedback and
// Zero/Ones/Parity flags, two stages with valid/ready handshaking.
module logic_unit_pipe #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       Op,
    input  logic             Acc,
    input  logic             Acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Out,
    output logic             Zero,
    output logic             Ones,
    output logic             Parity
);

    typedef enum logic [2:0] {
        OP_AND  = 3'b000,
        OP_OR   = 3'b001,
        OP_XOR  = 3'b010,
        OP_XNOR = 3'b011,
        OP_NAND = 3'b100,
        OP_NOR  = 3'b101,
        OP_ANDN = 3'b110,
        OP_NOTA = 3'b111
    } op_e;

    logic             s1_v;
    logic             s2_v;
    logic [WIDTH-1:0] s1_r;
    logic [WIDTH-1:0] acc;

    logic             accept;
    logic             s1_adv;
    logic [WIDTH-1:0] beff;
    logic [WIDTH-1:0] res;

    // Ready only looks at pipeline occupancy and out_ready, never in_valid.
    assign in_ready  = !s1_v || !s2_v || out_ready;
    assign accept    = in_valid && in_ready;
    assign s1_adv    = s1_v && (!s2_v || out_ready);
    assign out_valid = s2_v;

    // A clear in the same cycle as an accumulate feeds zero as operand B.
    always_comb begin
        beff = B;
        if (Acc) begin
            beff = Acc_clr ? '0 : acc;
        end
    end

    always_comb begin
        res = '0;
        case (op_e'(Op))
            OP_AND:  res = A & beff;
            OP_OR:   res = A | beff;
            OP_XOR:  res = A ^ beff;
            OP_XNOR: res = ~(A ^ beff);
            OP_NAND: res = ~(A & beff);
            OP_NOR:  res = ~(A | beff);
            OP_ANDN: res = A & ~beff;
            OP_NOTA: res = ~A;
            default: res = '0;
        endcase
    end

    // Stage 1 and the accumulator; ACC updates at accept so chained ops see it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_v <= 1'b0;
            s1_r <= '0;
            acc  <= '0;
        end else begin
            if (accept) begin
                s1_v <= 1'b1;
                s1_r <= res;
            end else if (s1_adv) begin
                s1_v <= 1'b0;
            end

            if (accept && Acc) begin
                acc <= res;
            end else if (Acc_clr) begin
                acc <= '0;
            end
        end
    end

    // Stage 2 holds result and flags stable while the consumer stalls.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_v   <= 1'b0;
            Out    <= '0;
            Zero   <= 1'b0;
            Ones   <= 1'b0;
            Parity <= 1'b0;
        end else begin
            if (s1_adv) begin
                s2_v   <= 1'b1;
                Out    <= s1_r;
                Zero   <= ~|s1_r;
                Ones   <= &s1_r;
                Parity <= ^s1_r;
            end else if (out_ready) begin
                s2_v <= 1'b0;
            end
        end
    end

endmodule
